multicycle_controller: RTL and testbench

//  Control FSM that sequences a multicycle RV32I-subset datapath (lw, sw, R-type, I-ALU, beq, jal).
//  All datapath state shares one ALU and one unified memory port, so each instruction takes 3-5 states.
//  Per state it drives mux selects, write strobes, ImmSrc and ALUControl.

---
 rtl/riscv_pkg.sv | 32 +++
 rtl/alu_decoder.sv | 30 +++
 rtl/multicycle_controller.sv | 173 +++++++++++++++++
 tb/tb_multicycle_controller.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types and encodings for the multicycle RV32I-subset controller.
// Opcodes, ALU operation codes and the FSM state enum live here.
package riscv_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    EXECR,
    EXECI,
    ALUWB,
    BEQ,
    JAL
  } statetype;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

endpackage

// File: rtl/alu_decoder.sv
// Maps ALUOp plus instruction fields to an ALU operation code.
// Purely combinational so it can be shared with a single-cycle controller.
module alu_decoder
  import riscv_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       op_b5,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      2'b01: alu_control = ALU_SUB;
      2'b10: begin
        case (funct3)
          3'b000:  alu_control = (op_b5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for a multicycle RV32I-subset datapath with a memory-ready
// handshake and a retired-instruction counter.
//
// state    | meaning
// FETCH    | read instruction at PC, PC+4 -> PC when memory ready
// DECODE   | read registers, compute branch target OldPC+imm
// MEMADR   | compute load/store address rs1+imm
// MEMREAD  | load access, wait for memory ready
// MEMWB    | write loaded data to rd
// MEMWRITE | store access, wait for memory ready
// EXECR    | R-type ALU operation
// EXECI    | I-type ALU operation
// ALUWB    | write ALUOut to rd
// BEQ      | compare rs1/rs2, take branch on Zero
// JAL      | PC <- target, compute OldPC+4 link value
module multicycle_controller
  import riscv_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic             RegWrite,
  output logic [1:0]       ImmSrc,
  output logic [2:0]       ALUControl,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  statetype   state, state_next;
  logic [1:0] alu_op;
  logic       pc_write_raw, ir_write_raw, reg_write_raw, mem_write_raw, illegal_raw;
  logic       retire;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= FETCH;
      instret <= '0;
    end else begin
      state <= state_next;
      if (retire) instret <= instret + 1'b1;
    end
  end

  always_comb begin
    state_next    = state;
    AdrSrc        = 1'b0;
    ResultSrc     = 2'b00;
    ALUSrcA       = 2'b00;
    ALUSrcB       = 2'b00;
    alu_op        = 2'b00;
    pc_write_raw  = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    mem_write_raw = 1'b0;
    illegal_raw   = 1'b0;
    retire        = 1'b0;
    case (state)
      FETCH: begin
        ALUSrcB      = 2'b10;
        ResultSrc    = 2'b10;
        pc_write_raw = mem_ready;
        ir_write_raw = mem_ready;
        if (mem_ready) state_next = DECODE;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_R:         state_next = EXECR;
          OP_I:         state_next = EXECI;
          OP_BEQ:       state_next = BEQ;
          OP_JAL:       state_next = JAL;
          default: begin
            state_next  = FETCH;
            illegal_raw = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        state_next = op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ready) state_next = MEMWB;
      end
      MEMWB: begin
        ResultSrc     = 2'b01;
        reg_write_raw = 1'b1;
        retire        = 1'b1;
        state_next    = FETCH;
      end
      MEMWRITE: begin
        AdrSrc        = 1'b1;
        mem_write_raw = 1'b1;
        if (mem_ready) begin
          retire     = 1'b1;
          state_next = FETCH;
        end
      end
      EXECR: begin
        ALUSrcA    = 2'b10;
        alu_op     = 2'b10;
        state_next = ALUWB;
      end
      EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        alu_op     = 2'b10;
        state_next = ALUWB;
      end
      ALUWB: begin
        reg_write_raw = 1'b1;
        retire        = 1'b1;
        state_next    = FETCH;
      end
      BEQ: begin
        ALUSrcA      = 2'b10;
        alu_op       = 2'b01;
        pc_write_raw = Zero;
        retire       = 1'b1;
        state_next   = FETCH;
      end
      JAL: begin
        ALUSrcA      = 2'b01;
        ALUSrcB      = 2'b10;
        pc_write_raw = 1'b1;
        state_next   = ALUWB;
      end
      default: state_next = FETCH;
    endcase
  end

  // Strobes are suppressed while reset is held so a reset mid-access leaves no side effects.
  assign PCWrite  = rst & pc_write_raw;
  assign IRWrite  = rst & ir_write_raw;
  assign RegWrite = rst & reg_write_raw;
  assign MemWrite = rst & mem_write_raw;
  assign illegal  = rst & illegal_raw;

  always_comb begin
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .op_b5       (op[5]),
    .funct7b5    (funct7b5),
    .alu_control (ALUControl)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: instruction-level step model
// checked against the DUT every cycle, plus literal spot checks.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [6:0]  op = 7'b0;
  logic [2:0]  funct3 = 3'b0;
  logic        funct7b5 = 1'b0;
  logic        Zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0]  ALUControl;
  logic [31:0] instret;

  multicycle_controller #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .illegal(illegal), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef enum int {S_F, S_D, S_ILL, S_MA, S_MR, S_WB, S_MW, S_XR, S_XI, S_AW, S_BQ, S_JL} step_t;

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       memw;
    logic       irw;
    logic [1:0] res;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic       regw;
    logic [1:0] imm;
    logic [2:0] alu;
    logic       ill;
  } outs_t;

  outs_t       exp_o;
  logic        exp_valid = 1'b0;
  step_t       cur_step = S_F;
  logic [31:0] model_cnt = 32'd0;
  int          n_tests = 0;
  int          n_fail = 0;
  int          memw_cycles = 0;
  int          pcw_cycles = 0;

  function automatic outs_t expected(step_t s, logic rdy, logic z, logic [6:0] o,
                                     logic [2:0] f3, logic f7);
    outs_t e;
    e = '0;
    case (o)
      7'b0100011: e.imm = 2'b01;
      7'b1100011: e.imm = 2'b10;
      7'b1101111: e.imm = 2'b11;
      default:    e.imm = 2'b00;
    endcase
    e.alu = 3'b000;
    if (s == S_BQ) e.alu = 3'b001;
    if (s == S_XR || s == S_XI) begin
      case (f3)
        3'b000:  e.alu = (o == 7'b0110011 && f7) ? 3'b001 : 3'b000;
        3'b010:  e.alu = 3'b101;
        3'b110:  e.alu = 3'b011;
        3'b111:  e.alu = 3'b010;
        default: e.alu = 3'b000;
      endcase
    end
    case (s)
      S_F:   begin e.srcb = 2'b10; e.res = 2'b10; e.pcw = rdy; e.irw = rdy; end
      S_D:   begin e.srca = 2'b01; e.srcb = 2'b01; end
      S_ILL: begin e.srca = 2'b01; e.srcb = 2'b01; e.ill = 1'b1; end
      S_MA:  begin e.srca = 2'b10; e.srcb = 2'b01; end
      S_MR:  e.adr = 1'b1;
      S_WB:  begin e.res = 2'b01; e.regw = 1'b1; end
      S_MW:  begin e.adr = 1'b1; e.memw = 1'b1; end
      S_XR:  e.srca = 2'b10;
      S_XI:  begin e.srca = 2'b10; e.srcb = 2'b01; end
      S_AW:  e.regw = 1'b1;
      S_BQ:  begin e.srca = 2'b10; e.pcw = z; end
      S_JL:  begin e.srca = 2'b01; e.srcb = 2'b10; e.pcw = 1'b1; end
      default: e = e;
    endcase
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    outs_t got;
    got = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           RegWrite, ImmSrc, ALUControl, illegal};
    if (exp_valid && rst) begin
      n_tests++;
      if (got !== exp_o) begin
        n_fail++;
        $display("FAIL outputs step=%0d t=%0t: got %0h, expected %0h", cur_step, $time, got, exp_o);
      end
      n_tests++;
      if (instret !== model_cnt) begin
        n_fail++;
        $display("FAIL instret t=%0t: got %0d, expected %0d", $time, instret, model_cnt);
      end
      if (MemWrite) memw_cycles++;
      if (PCWrite) pcw_cycles++;
    end
  end

  // Drives one instruction from FETCH, assuming the DUT sits in FETCH at posedge+1.
  task automatic run(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z,
                     input int fstall, input int mstall, input logic other_rdy, input int abort_step);
    step_t steps[$];
    steps = {S_F};
    case (o)
      7'b0000011: steps = {steps, S_D, S_MA, S_MR, S_WB};
      7'b0100011: steps = {steps, S_D, S_MA, S_MW};
      7'b0110011: steps = {steps, S_D, S_XR, S_AW};
      7'b0010011: steps = {steps, S_D, S_XI, S_AW};
      7'b1100011: steps = {steps, S_D, S_BQ};
      7'b1101111: steps = {steps, S_D, S_JL, S_AW};
      default:    steps = {steps, S_ILL};
    endcase
    op = o; funct3 = f3; funct7b5 = f7; Zero = z;
    foreach (steps[i]) begin
      bit waits;
      int w;
      waits = (steps[i] == S_F || steps[i] == S_MR || steps[i] == S_MW);
      w = (steps[i] == S_F) ? fstall : (waits ? mstall : 0);
      for (int k = 0; k <= w; k++) begin
        mem_ready = waits ? (k == w) : other_rdy;
        cur_step  = steps[i];
        exp_o     = expected(steps[i], mem_ready, z, o, f3, f7);
        exp_valid = 1'b1;
        if (i == abort_step && k == 1) return;
        @(posedge clk);
        if (steps[i] == S_WB || steps[i] == S_AW || steps[i] == S_BQ ||
            (steps[i] == S_MW && mem_ready)) model_cnt++;
        #1;
      end
    end
  endtask

  initial begin
    mem_ready = 1'b1;
    #3;
    check("reset_instret", instret, 32'd0);
    check("reset_strobes", {PCWrite, IRWrite, RegWrite, MemWrite, illegal}, 32'd0);
    check("reset_fetch_sel", {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc}, 32'b0_00_10_10);
    mem_ready = 1'b0;
    #9 rst = 1'b1;
    @(posedge clk); #1;

    // 1: lw, no stalls
    run(7'b0000011, 3'b010, 1'b0, 1'b0, 0, 0, 1'b1, -1);
    check("lw_instret", instret, 32'd1);

    // 2: sw stalled two cycles in MEMWRITE
    memw_cycles = 0;
    run(7'b0100011, 3'b010, 1'b0, 1'b0, 0, 2, 1'b1, -1);
    check("sw_memwrite_cycles", memw_cycles, 32'd3);
    check("sw_instret", instret, 32'd2);

    // 3: beq taken / not taken
    pcw_cycles = 0;
    run(7'b1100011, 3'b000, 1'b0, 1'b1, 0, 0, 1'b1, -1);
    check("beq_taken_pcwrites", pcw_cycles, 32'd2);
    pcw_cycles = 0;
    run(7'b1100011, 3'b000, 1'b0, 1'b0, 0, 0, 1'b1, -1);
    check("beq_nottaken_pcwrites", pcw_cycles, 32'd1);

    // 4: ALU decode variants
    run(7'b0110011, 3'b000, 1'b1, 1'b0, 0, 0, 1'b1, -1);
    run(7'b0010011, 3'b000, 1'b1, 1'b0, 0, 0, 1'b1, -1);
    run(7'b0110011, 3'b000, 1'b0, 1'b0, 0, 0, 1'b1, -1);
    run(7'b0110011, 3'b111, 1'b0, 1'b0, 0, 0, 1'b0, -1);
    run(7'b0110011, 3'b110, 1'b0, 1'b0, 0, 0, 1'b1, -1);
    run(7'b0010011, 3'b010, 1'b0, 1'b0, 0, 0, 1'b1, -1);
    run(7'b0010011, 3'b100, 1'b0, 1'b0, 0, 0, 1'b1, -1);
    check("alu_instret", instret, 32'd11);

    // 5: unsupported opcode
    run(7'b1111111, 3'b000, 1'b0, 1'b0, 0, 0, 1'b1, -1);
    check("illegal_instret", instret, 32'd11);

    run(7'b1101111, 3'b000, 1'b0, 1'b0, 0, 0, 1'b1, -1);
    check("jal_instret", instret, 32'd12);
    run(7'b0000011, 3'b010, 1'b0, 1'b0, 3, 2, 1'b0, -1);
    check("lw_stalled_instret", instret, 32'd13);

    // 6: reset during MEMWRITE
    run(7'b0100011, 3'b010, 1'b0, 1'b0, 0, 3, 1'b1, 3);
    exp_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("rst_memwrite", MemWrite, 32'd0);
    check("rst_instret", instret, 32'd0);
    check("rst_fetch_sel", {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc}, 32'b0_00_10_10);
    mem_ready = 1'b1;
    #1;
    check("rst_ir_pc_gated", {IRWrite, PCWrite}, 32'd0);
    @(posedge clk); #1;
    check("rst_hold_regwrite", {RegWrite, MemWrite}, 32'd0);
    mem_ready = 1'b0;
    #2 rst = 1'b1;
    model_cnt = 32'd0;
    @(posedge clk); #1;
    check("post_rst_fetch_wait", {IRWrite, ALUSrcB, ResultSrc}, 32'b0_10_10);
    run(7'b0000011, 3'b010, 1'b0, 1'b0, 2, 0, 1'b1, -1);
    check("post_rst_instret", instret, 32'd1);

    exp_valid = 1'b0;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

endmodule
